// File: rtl/rbw_replay_if.sv
// rbw_replay_if: read-issue, write-observe and replay signals of the
// rbw_replay parking stage. The master modport is the surrounding pipeline;
// the slave modport is the parking stage itself.
interface rbw_replay_if #(
    parameter int L  = 0,
    parameter int TW = 3
);
    logic          i_rd_v;
    logic          i_rd_ts;
    logic [L:0]    i_rd_adr;
    logic [TW:0]   i_rd_tag;
    logic          i_rbw;
    logic          o_rd_rdy;
    logic          ws;
    logic          w_ts;
    logic [L:0]    ws_adr;
    logic          o_rp_v;
    logic          o_rp_ts;
    logic [L:0]    o_rp_adr;
    logic [TW:0]   o_rp_tag;
    logic          i_rp_rdy;
    logic          o_full;
    logic          o_empty;
    logic          o_err;

    modport master (
        output i_rd_v, i_rd_ts, i_rd_adr, i_rd_tag, i_rbw,
        output ws, w_ts, ws_adr, i_rp_rdy,
        input  o_rd_rdy, o_rp_v, o_rp_ts, o_rp_adr, o_rp_tag,
        input  o_full, o_empty, o_err
    );

    modport slave (
        input  i_rd_v, i_rd_ts, i_rd_adr, i_rd_tag, i_rbw,
        input  ws, w_ts, ws_adr, i_rp_rdy,
        output o_rd_rdy, o_rp_v, o_rp_ts, o_rp_adr, o_rp_tag,
        output o_full, o_empty, o_err
    );
endinterface

// File: rtl/rbw_replay.sv
// rbw_replay: parks reads flagged by the read-before-write checker, watches
// the write stream for the write that resolves each one, and re-issues the
// read on a valid/ready replay port.
// Optional feature: define RBW_REPLAY_TIMEOUT_EN to age unresolved slots,
// drop them after TO cycles and raise the sticky o_err flag.
module rbw_replay #(
    parameter int L  = 0,
    parameter int TW = 3,
    parameter int D  = 4,
    parameter int TO = 15
) (
    input  logic       clk,
    input  logic       a_rst,
    rbw_replay_if.slave bus
);
    localparam int SW = $clog2(D);

    logic [D-1:0]         vld_q, res_q, ts_q;
    logic [D-1:0][L:0]    adr_q;
    logic [D-1:0][TW:0]   tag_q;
    logic [SW-1:0]        sel_q;
    logic                 hold_q;

    logic [D-1:0]         vld_n, res_n;
    logic [SW-1:0]        alloc_idx, pick_idx, sel_n;
    logic                 full, park, park_res, rp_v, accept, keep_sel;

`ifdef RBW_REPLAY_TIMEOUT_EN
    localparam int AW = (TO > 0) ? $clog2(TO + 1) : 1;
    logic [D-1:0][AW-1:0] age_q;
    logic                 err_q;
    logic                 to_evt;
`endif

    assign full     = &vld_q;
    assign park     = bus.i_rd_v & bus.i_rbw & ~full;
    assign park_res = bus.ws & (bus.w_ts == bus.i_rd_ts) & (bus.ws_adr == bus.i_rd_adr);
    assign rp_v     = vld_q[sel_q] & res_q[sel_q];
    assign accept   = rp_v & bus.i_rp_rdy;

    // Lowest-index free slot, taken from registered state only (no same-cycle reuse).
    always_comb begin
        alloc_idx = '0;
        for (int i = D - 1; i >= 0; i--) begin
            if (!vld_q[i]) alloc_idx = SW'(i);
        end
    end

    // Next slot flags (resolve, timeout, accept, park) and next replay pointer.
    always_comb begin
        vld_n = vld_q;
        res_n = res_q;
`ifdef RBW_REPLAY_TIMEOUT_EN
        to_evt = 1'b0;
`endif
        for (int i = 0; i < D; i++) begin
            if (vld_q[i] && !res_q[i] && bus.ws && (ts_q[i] == bus.w_ts) && (adr_q[i] == bus.ws_adr))
                res_n[i] = 1'b1;
        end
`ifdef RBW_REPLAY_TIMEOUT_EN
        // A slot resolved in its last cycle is kept rather than timed out.
        for (int i = 0; i < D; i++) begin
            if (vld_q[i] && !res_n[i] && (age_q[i] == AW'(TO))) begin
                vld_n[i] = 1'b0;
                to_evt   = 1'b1;
            end
        end
`endif
        if (accept) begin
            vld_n[sel_q] = 1'b0;
            res_n[sel_q] = 1'b0;
        end
        if (park) begin
            vld_n[alloc_idx] = 1'b1;
            res_n[alloc_idx] = park_res;
        end
        pick_idx = '0;
        for (int i = D - 1; i >= 0; i--) begin
            if (vld_n[i] && res_n[i]) pick_idx = SW'(i);
        end
        // An offer that was refused stays on the port until it is taken.
        keep_sel = hold_q ? ~accept : (rp_v & ~bus.i_rp_rdy);
        sel_n    = keep_sel ? sel_q : pick_idx;
    end

    // Slot array, replay pointer and hold flag.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            vld_q  <= '0;
            res_q  <= '0;
            ts_q   <= '0;
            adr_q  <= '0;
            tag_q  <= '0;
            sel_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            vld_q  <= vld_n;
            res_q  <= res_n;
            sel_q  <= sel_n;
            hold_q <= keep_sel;
            if (park) begin
                ts_q[alloc_idx]  <= bus.i_rd_ts;
                adr_q[alloc_idx] <= bus.i_rd_adr;
                tag_q[alloc_idx] <= bus.i_rd_tag;
            end
        end
    end

`ifdef RBW_REPLAY_TIMEOUT_EN
    // Age counters for unresolved slots and the sticky timeout flag.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            age_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | to_evt;
            for (int i = 0; i < D; i++) begin
                if (park && (alloc_idx == SW'(i)))
                    age_q[i] <= '0;
                else if (vld_q[i] && !res_n[i])
                    age_q[i] <= (age_q[i] == AW'(TO)) ? '0 : age_q[i] + 1'b1;
            end
        end
    end

    assign bus.o_err = err_q;
`else
    // Without timeouts o_err is tied low (TO is never negative).
    assign bus.o_err = (TO < 0);
`endif

    assign bus.o_rp_v   = rp_v;
    assign bus.o_rp_ts  = rp_v & ts_q[sel_q];
    assign bus.o_rp_adr = rp_v ? adr_q[sel_q] : '0;
    assign bus.o_rp_tag = rp_v ? tag_q[sel_q] : '0;
    assign bus.o_full   = full;
    assign bus.o_empty  = ~|vld_q;
    assign bus.o_rd_rdy = ~full;
endmodule

// File: tb/tb_rbw_replay.sv
// tb_rbw_replay: directed scenarios plus randomized traffic, checked every
// cycle against a slot-list model of the parking stage.
module tb_rbw_replay;
    localparam int L  = 3;
    localparam int TW = 3;
    localparam int D  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic a_rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rbw_replay_if #(.L(L), .TW(TW)) b();

    rbw_replay #(.L(L), .TW(TW), .D(D), .TO(TO)) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .bus   (b)
    );

    // Model: list of parked reads plus the index currently held on the port.
    bit m_vld [D];
    bit m_res [D];
    bit m_ts  [D];
    int m_adr [D];
    int m_tag [D];
    int m_age [D];
    int m_held;
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_offer();
        if (m_held >= 0) return m_held;
        for (int i = 0; i < D; i++)
            if (m_vld[i] && m_res[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < D; i++) begin
            m_vld[i] = 0; m_res[i] = 0; m_ts[i] = 0;
            m_adr[i] = 0; m_tag[i] = 0; m_age[i] = 0;
        end
        m_held = -1;
        m_err  = 0;
    endtask

    // Advance the model by one clock using the inputs of the cycle just ended.
    task automatic m_step();
        int off;
        int fr;
        if (a_rst) begin
            m_reset();
            return;
        end
        off = m_offer();
        fr  = -1;
        for (int i = D - 1; i >= 0; i--)
            if (!m_vld[i]) fr = i;
        for (int i = 0; i < D; i++)
            if (m_vld[i] && !m_res[i] && b.ws && (m_ts[i] == b.w_ts) && (m_adr[i] == int'(b.ws_adr)))
                m_res[i] = 1;
`ifdef RBW_REPLAY_TIMEOUT_EN
        for (int i = 0; i < D; i++)
            if (m_vld[i] && !m_res[i]) begin
                if (m_age[i] == TO) begin
                    m_vld[i] = 0;
                    m_err    = 1;
                end else begin
                    m_age[i]++;
                end
            end
`endif
        if (off >= 0 && b.i_rp_rdy) begin
            m_vld[off] = 0;
            m_res[off] = 0;
            m_held     = -1;
        end else begin
            m_held = off;
        end
        if (b.i_rd_v && b.i_rbw && fr >= 0) begin
            m_vld[fr] = 1;
            m_ts[fr]  = b.i_rd_ts;
            m_adr[fr] = int'(b.i_rd_adr);
            m_tag[fr] = int'(b.i_rd_tag);
            m_age[fr] = 0;
            m_res[fr] = b.ws && (b.w_ts == b.i_rd_ts) && (b.ws_adr == b.i_rd_adr);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            int  off;
            bit  all_v;
            bit  none_v;
            @(negedge clk);
            off    = m_offer();
            all_v  = 1;
            none_v = 1;
            for (int i = 0; i < D; i++) begin
                all_v  &= m_vld[i];
                none_v &= !m_vld[i];
            end
            chk("cmp_rp_v",   32'(b.o_rp_v),   32'(off >= 0));
            chk("cmp_rp_ts",  32'(b.o_rp_ts),  (off >= 0) ? 32'(m_ts[off]) : 32'd0);
            chk("cmp_rp_adr", 32'(b.o_rp_adr), (off >= 0) ? 32'(m_adr[off]) : 32'd0);
            chk("cmp_rp_tag", 32'(b.o_rp_tag), (off >= 0) ? 32'(m_tag[off]) : 32'd0);
            chk("cmp_full",   32'(b.o_full),   32'(all_v));
            chk("cmp_empty",  32'(b.o_empty),  32'(none_v));
            chk("cmp_rd_rdy", 32'(b.o_rd_rdy), 32'(!all_v));
            chk("cmp_err",    32'(b.o_err),    32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle();
        b.i_rd_v   = 0; b.i_rd_ts = 0; b.i_rd_adr = '0; b.i_rd_tag = '0; b.i_rbw = 0;
        b.ws       = 0; b.w_ts    = 0; b.ws_adr   = '0;
        b.i_rp_rdy = 0;
    endtask

    task automatic drv_rd(input int ts, input int adr, input int tag);
        b.i_rd_v   = 1;
        b.i_rbw    = 1;
        b.i_rd_ts  = ts[0];
        b.i_rd_adr = (L+1)'(adr);
        b.i_rd_tag = (TW+1)'(tag);
    endtask

    task automatic drv_ws(input int ts, input int adr);
        b.ws     = 1;
        b.w_ts   = ts[0];
        b.ws_adr = (L+1)'(adr);
    endtask

    initial begin
        m_reset();
        a_rst = 1;
        idle();
        repeat (3) cyc();
        chk("rst_rp_v",   32'(b.o_rp_v),   0);
        chk("rst_rd_rdy", 32'(b.o_rd_rdy), 1);
        chk("rst_full",   32'(b.o_full),   0);
        chk("rst_empty",  32'(b.o_empty),  1);
        chk("rst_err",    32'(b.o_err),    0);
        a_rst = 0;

        // Park then resolve; a write on the other task selector does not count.
        cyc(); idle(); drv_rd(0, 5, 2);
        cyc(); idle();
        chk("park_not_empty", 32'(b.o_empty), 0);
        chk("park_no_replay", 32'(b.o_rp_v),  0);
        cyc(); idle(); drv_ws(1, 5);
        cyc(); idle(); drv_ws(0, 5);
        chk("wrong_ts_no_resolve", 32'(b.o_rp_v), 0);
        cyc(); idle(); b.i_rp_rdy = 1;
        chk("resolve_rp_v",   32'(b.o_rp_v),   1);
        chk("resolve_rp_adr", 32'(b.o_rp_adr), 5);
        chk("resolve_rp_tag", 32'(b.o_rp_tag), 2);
        cyc(); idle();
        chk("resolve_drained", 32'(b.o_empty), 1);

        // Park and matching write in the same cycle.
        cyc(); idle(); drv_rd(0, 7, 9); drv_ws(0, 7);
        cyc(); idle(); b.i_rp_rdy = 1;
        chk("same_cyc_rp_v",   32'(b.o_rp_v),   1);
        chk("same_cyc_rp_adr", 32'(b.o_rp_adr), 7);
        chk("same_cyc_rp_tag", 32'(b.o_rp_tag), 9);
        cyc(); idle();
        chk("same_cyc_drained", 32'(b.o_empty), 1);

        // Refused offer of slot 2 stays put while slot 0 resolves.
        cyc(); idle(); drv_rd(0, 1, 0);
        cyc(); idle(); drv_rd(0, 2, 1);
        cyc(); idle(); drv_rd(0, 3, 2);
        cyc(); idle(); drv_ws(0, 3);
        cyc(); idle(); drv_ws(0, 1);
        chk("hold_first_tag", 32'(b.o_rp_tag), 2);
        cyc(); idle();
        chk("hold_stable_tag", 32'(b.o_rp_tag), 2);
        cyc(); idle(); b.i_rp_rdy = 1;
        chk("hold_still_tag", 32'(b.o_rp_tag), 2);
        cyc(); idle(); b.i_rp_rdy = 1;
        chk("hold_next_v",   32'(b.o_rp_v),   1);
        chk("hold_next_tag", 32'(b.o_rp_tag), 0);
        cyc(); idle(); drv_ws(0, 2);
        chk("hold_gap_v", 32'(b.o_rp_v), 0);
        cyc(); idle(); b.i_rp_rdy = 1;
        chk("hold_last_tag", 32'(b.o_rp_tag), 1);
        cyc(); idle();
        chk("hold_drained", 32'(b.o_empty), 1);

        // Fill all slots, refuse a fifth, free one and capture it.
        for (int k = 0; k < 4; k++) begin
            cyc(); idle(); drv_rd(0, 8 + k, 4 + k);
        end
        cyc(); idle();
        chk("full_flag",   32'(b.o_full),   1);
        chk("full_rd_rdy", 32'(b.o_rd_rdy), 0);
        drv_rd(1, 12, 15); drv_ws(0, 8);
        cyc(); b.ws = 0; b.i_rp_rdy = 1;
        chk("full_rp_tag",  32'(b.o_rp_tag), 4);
        chk("full_held",    32'(b.o_full),   1);
        cyc(); b.i_rp_rdy = 0;
        chk("full_freed_rdy", 32'(b.o_rd_rdy), 1);
        cyc(); idle();
        chk("full_refilled", 32'(b.o_full), 1);
        for (int k = 0; k < 4; k++) begin
            cyc(); idle(); b.i_rp_rdy = 1;
            if (k < 3) drv_ws(0, 9 + k); else drv_ws(1, 12);
        end
        repeat (6) begin
            cyc(); idle(); b.i_rp_rdy = 1;
        end
        cyc(); idle();
        chk("full_drained", 32'(b.o_empty), 1);

        // Asynchronous reset in the middle of a refused replay.
        cyc(); idle(); drv_rd(0, 4, 3); drv_ws(0, 4);
        cyc(); idle(); drv_rd(0, 6, 5);
        chk("mid_rst_offer", 32'(b.o_rp_v), 1);
        cyc(); idle();
        #2 a_rst = 1; m_reset();
        #1;
        chk("mid_rst_rp_v",   32'(b.o_rp_v),   0);
        chk("mid_rst_rp_tag", 32'(b.o_rp_tag), 0);
        chk("mid_rst_empty",  32'(b.o_empty),  1);
        chk("mid_rst_rd_rdy", 32'(b.o_rd_rdy), 1);
        chk("mid_rst_err",    32'(b.o_err),    0);
        cyc(); cyc(); a_rst = 0;
        cyc(); idle(); drv_ws(0, 6); b.i_rp_rdy = 1;
        cyc(); idle(); drv_ws(0, 4); b.i_rp_rdy = 1;
        cyc(); idle(); b.i_rp_rdy = 1;
        chk("post_rst_no_replay", 32'(b.o_rp_v), 0);
        cyc(); idle();
        chk("post_rst_no_replay2", 32'(b.o_rp_v), 0);
        chk("post_rst_empty",      32'(b.o_empty), 1);

`ifdef RBW_REPLAY_TIMEOUT_EN
        // Unresolved slot is dropped after TO cycles of age and flags o_err.
        cyc(); idle(); drv_rd(0, 3, 1);
        repeat (TO + 1) begin
            cyc(); idle();
        end
        chk("to_still_parked", 32'(b.o_empty), 0);
        cyc(); idle();
        chk("to_freed", 32'(b.o_empty), 1);
        chk("to_err",   32'(b.o_err),   1);
        chk("to_no_rp", 32'(b.o_rp_v),  0);
        cyc(); idle(); drv_ws(0, 3);
        cyc(); idle();
        cyc(); idle();
        chk("to_err_sticky", 32'(b.o_err),  1);
        chk("to_never_rp",   32'(b.o_rp_v), 0);
`endif

        // Randomized traffic over a small address space to force collisions.
        repeat (3000) begin
            cyc();
            b.i_rd_v   = ($urandom_range(0, 9) < 6);
            b.i_rbw    = ($urandom_range(0, 3) != 0);
            b.i_rd_ts  = 1'($urandom_range(0, 1));
            b.i_rd_adr = (L+1)'($urandom_range(0, 3));
            b.i_rd_tag = (TW+1)'($urandom_range(0, 15));
            b.ws       = ($urandom_range(0, 9) < 4);
            b.w_ts     = 1'($urandom_range(0, 1));
            b.ws_adr   = (L+1)'($urandom_range(0, 3));
            b.i_rp_rdy = ($urandom_range(0, 1) == 1);
        end

        // Drain: sweep every (ts, adr) pair with the consumer always ready.
        for (int k = 0; k < 64; k++) begin
            cyc(); idle(); b.i_rp_rdy = 1;
            drv_ws(k % 2, (k / 2) % 4);
        end
        repeat (4) begin
            cyc(); idle(); b.i_rp_rdy = 1;
        end
        cyc(); idle();
        chk("final_empty", 32'(b.o_empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rbw_replay.md
# rbw_replay

Parking and replay stage directly downstream of the per-instance read-before-write checker. A read that the checker flags (its `o_rbw` fed in here as `i_rbw`) is parked in a small slot array. The stage then watches the write stream for the write that resolves that read, and re-issues the read through a valid/ready replay port once the write has been seen. Upstream issue logic stalls only when every slot is occupied.

## Interface
Parameters:
- `L`, 0, MSB index of read/write addresses (address width L+1)
- `TW`, 3, MSB index of the read tag (tag width TW+1)
- `D`, 4, number of park slots (2..16)
- `TO`, 15, timeout in cycles for a parked, unresolved slot (only used with `RBW_REPLAY_TIMEOUT_EN`)

Ports:
- `clk` in 1: clock, all state on rising edge
- `a_rst` in 1: asynchronous reset, active-high
- `i_rd_v` in 1: read issue valid
- `i_rd_ts` in 1: read task selector
- `i_rd_adr` in L+1: read address
- `i_rd_tag` in TW+1: read tag, returned unchanged on replay
- `i_rbw` in 1: hazard flag for this read, same cycle as `i_rd_v`
- `o_rd_rdy` out 1: a free slot exists
- `ws` in 1: write select observed
- `w_ts` in 1: write task selector
- `ws_adr` in L+1: write address
- `o_rp_v` out 1: replay valid
- `o_rp_ts` out 1: replay task selector
- `o_rp_adr` out L+1: replay address
- `o_rp_tag` out TW+1: replay tag
- `i_rp_rdy` in 1: replay consumer ready
- `o_full` out 1: all D slots valid
- `o_empty` out 1: no slot valid
- `o_err` out 1: sticky timeout flag

## Operation
- **Slot contents:** `vld`, `res` (resolved), `ts`, `adr`, `tag`, plus `age` when the timeout macro is defined.
- **Park:** `i_rd_v & i_rbw & o_rd_rdy` allocates the lowest-index free slot, with `vld=1`.
  - `res=1` if that same cycle has `ws & w_ts==i_rd_ts & ws_adr==i_rd_adr`; otherwise `res=0`.
- **Unflagged or refused reads:** `i_rd_v & ~i_rbw` is ignored, since the read proceeds elsewhere. A flagged read with `o_rd_rdy=0` is not captured; upstream must hold it.
- **Resolve:** each cycle, every slot with `vld & ~res & ts==w_ts & adr==ws_adr` gets `res=1` when `ws=1`. One write can resolve several slots.
- **Replay select:** a registered pointer `sel` plus a held flag `hold`.
  - With `hold=0`, `sel` is the lowest-index slot with `vld & res`.
  - `o_rp_v=1` while the selected slot is `vld & res`; `o_rp_*` is driven from that slot.
  - If `o_rp_v & ~i_rp_rdy`, `hold` is set and `sel` is frozen. The payload stays stable until accepted, even if a lower-index slot resolves.
- **Replay accept:** `o_rp_v & i_rp_rdy` clears `vld`/`res` of slot `sel` and clears `hold`.
- **Status:** `o_rd_rdy = ~o_full`. `o_full` and `o_empty` are computed from registered `vld` bits only. A slot freed in cycle N is allocatable from N+1; there is no same-cycle free-to-alloc reuse.
- **Reset** (async, any time, including mid-handshake):
  - All slots and parked reads are discarded; `sel=0`, `hold=0`.
  - Outputs: `o_rp_v=0`, `o_rp_*=0`, `o_rd_rdy=1`, `o_full=0`, `o_empty=1`, `o_err=0`.

## Timing
- **Park in cycle N, unresolved:** the slot is visible in N+1.
  - A matching write in cycle M ≥ N+1 gives `o_rp_v=1` in M+1 at the earliest.
- **Park and matching write both in cycle N:** `o_rp_v=1` in N+1.
- **Early write:** a write in N-1 or earlier does not resolve a read parked in N.
- **Throughput:** one replay per cycle at most; back-to-back replays occur when `i_rp_rdy` stays high.
- **Simultaneous park and replay:** allowed in the same cycle and target different slots.
- **Full:** with D valid slots, the next free slot is allocatable one cycle after a replay accept.

## Configuration
- **`RBW_REPLAY_TIMEOUT_EN` defined:**
  - Each `vld & ~res` slot increments `age` (width clog2(TO+1)) every cycle; `age` is 0 at allocation.
  - When `age==TO`, the slot is freed in the next cycle and `o_err` is set. `o_err` stays set until reset.
  - Resolved slots do not age.
- **`RBW_REPLAY_TIMEOUT_EN` undefined:** no age counters, `o_err` is constant 0, `TO` is unused, and slots wait indefinitely.

## Test plan
- **Reset:** assert `a_rst` mid-replay → `o_rp_v=0`, `o_empty=1`, `o_rd_rdy=1`, `o_err=0` immediately; a prior parked read is never replayed.
- **Park then resolve:** park ts=0 adr=5 tag=2 at N; write ts=0 adr=5 at N+3 → `o_rp_v=1` at N+4 with adr=5 tag=2. A write with ts=1 adr=5 does not resolve it.
- **Same-cycle resolve:** park adr=7 together with a matching write in cycle N → `o_rp_v=1` at N+1.
- **Hold stability:** slot 2 resolved and offered with `i_rp_rdy=0`; slot 0 resolves → payload stays slot 2 until accepted, then slot 0 is replayed next cycle.
- **Full and stall:** D=4, park 4 reads → `o_full=1`, `o_rd_rdy=0`, and a 5th flagged read is not captured; after one accept, `o_rd_rdy=1` the next cycle.
- **Timeout (macro on, TO=15):** park adr=3 with no write → slot freed 16 cycles after allocation, `o_err=1` stays high, and no replay is issued.
